// File: rtl/vdp99_pkg.sv
// Shared encodings for the vdp99 CPU-port initiator: command ops, control-byte
// prefixes, FSM states and the command-to-byte-sequence mapping.
package vdp99_pkg;

  typedef enum logic [1:0] {
    OP_REG_WR  = 2'd0,
    OP_VRAM_WR = 2'd1,
    OP_VRAM_RD = 2'd2,
    OP_STAT_RD = 2'd3
  } op_e;

  localparam logic [7:0] REG_WR_PREFIX   = 8'h80;
  localparam logic [7:0] WR_SETUP_PREFIX = 8'h40;

  typedef enum logic [2:0] {C_IDLE, C_T1, C_T2, C_TW, C_T3, C_TH, C_GAP} cyc_state_e;
  typedef enum logic {S_IDLE, S_BUSY} seq_state_e;

  typedef struct packed {
    logic       mode;
    logic       is_read;
    logic [7:0] value;
  } bus_byte_t;

  function automatic logic [1:0] op_nbytes(input op_e op);
    case (op)
      OP_REG_WR:  return 2'd2;
      OP_STAT_RD: return 2'd1;
      default:    return 2'd3;
    endcase
  endfunction

  // Byte idx of the VDP sequence for a command; reads carry a zero data byte.
  function automatic bus_byte_t op_byte(input op_e op, input logic [13:0] addr,
                                        input logic [7:0] data, input logic [1:0] idx);
    bus_byte_t b;
    b = '0;
    case (op)
      OP_REG_WR: begin
        b.mode  = 1'b1;
        b.value = (idx == 2'd0) ? data : (REG_WR_PREFIX | {5'b0, addr[2:0]});
      end
      OP_VRAM_WR, OP_VRAM_RD: begin
        b.mode = (idx != 2'd2);
        if (idx == 2'd0)      b.value = addr[7:0];
        else if (idx == 2'd1) b.value = ((op == OP_VRAM_WR) ? WR_SETUP_PREFIX : 8'h00)
                                        | {2'b00, addr[13:8]};
        else begin
          b.value   = (op == OP_VRAM_WR) ? data : 8'h00;
          b.is_read = (op == OP_VRAM_RD);
        end
      end
      default: begin
        b.mode    = 1'b1;
        b.is_read = 1'b1;
      end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vdp99_cpu_master_z80_io_cycle.sv
// Single-byte Z80-style I/O cycle: T1 setup, T2/Tw/T3 strobe, TH hold, then GAP
// idle cycles. done marks the last cycle of the byte so the next can follow seamlessly.
module z80_io_cycle
  import vdp99_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int GAP_CYCLES  = 6
) (
  input  logic       phi,
  input  logic       reset,
  input  logic       start,
  input  logic       is_read,
  input  logic       mode,
  input  logic [7:0] data,
  output logic       done,
  output logic [7:0] rdata,
  output logic       vdp_mode,
  output logic [7:0] vdp_dout,
  output logic       vdp_wr,
  output logic       vdp_rd,
  input  logic [7:0] vdp_din
);

  cyc_state_e state_q, state_d;
  logic [2:0] wait_q;
  logic [5:0] gap_q;
  logic       mode_q, rd_q;
  logic [7:0] data_q;
  logic       drive, strobe;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      C_T1: state_d = C_T2;
      C_T2: state_d = (WAIT_STATES > 0) ? C_TW : C_T3;
      C_TW: if (wait_q == 3'd0) state_d = C_T3;
      C_T3: state_d = C_TH;
      C_TH: begin
        if (GAP_CYCLES > 0) state_d = C_GAP;
        else begin
          done    = 1'b1;
          state_d = C_IDLE;
        end
      end
      C_GAP: begin
        if (gap_q == 6'd0) begin
          done    = 1'b1;
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
    if (start) state_d = C_T1;
  end

  always_ff @(posedge phi or posedge reset) begin
    if (reset) begin
      state_q <= C_IDLE;
      wait_q  <= '0;
      gap_q   <= '0;
      mode_q  <= 1'b0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == C_T2)                      wait_q <= 3'(WAIT_STATES - 1);
      else if (state_q == C_TW && wait_q != '0) wait_q <= wait_q - 3'd1;
      if (state_q == C_TH)                      gap_q  <= 6'(GAP_CYCLES - 1);
      else if (state_q == C_GAP && gap_q != '0) gap_q  <= gap_q - 6'd1;
      if (start) begin
        mode_q <= mode;
        rd_q   <= is_read;
        data_q <= data;
      end
      // Read data is captured on the edge that ends T3.
      if (state_q == C_T3 && rd_q) rdata <= vdp_din;
    end
  end

  always_comb begin
    drive    = state_q inside {C_T1, C_T2, C_TW, C_T3, C_TH};
    strobe   = state_q inside {C_T2, C_TW, C_T3};
    vdp_mode = drive & mode_q;
    vdp_dout = drive ? data_q : 8'h00;
    vdp_wr   = strobe & ~rd_q;
    vdp_rd   = strobe & rd_q;
  end

endmodule

// File: rtl/vdp99_cpu_master.sv
// Command sequencer: turns one REG_WR/VRAM_WR/VRAM_RD/STAT_RD command into its
// VDP byte sequence, issuing bytes back to back through the I/O cycle engine.
module vdp99_cpu_master
  import vdp99_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int GAP_CYCLES  = 6
) (
  input  logic        phi,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [13:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        vdp_mode,
  output logic [7:0]  vdp_dout,
  input  logic [7:0]  vdp_din,
  output logic        vdp_wr,
  output logic        vdp_rd
);

  seq_state_e  state_q, state_d;
  op_e         op_q;
  logic [13:0] addr_q;
  logic [7:0]  data_q;
  logic [1:0]  idx_q;
  logic        accept, last, finish, start, done;
  logic [7:0]  rdata;
  bus_byte_t   nxt;

  always_comb begin
    accept  = (state_q == S_IDLE) && cmd_valid;
    last    = (idx_q == op_nbytes(op_q) - 2'd1);
    finish  = (state_q == S_BUSY) && done && last;
    start   = accept || ((state_q == S_BUSY) && done && !last);
    // On accept the first byte comes straight from the command inputs.
    nxt     = accept ? op_byte(op_e'(cmd_op), cmd_addr, cmd_data, 2'd0)
                     : op_byte(op_q, addr_q, data_q, idx_q + 2'd1);
    state_d = state_q;
    if (accept)      state_d = S_BUSY;
    else if (finish) state_d = S_IDLE;
  end

  assign cmd_ready = (state_q == S_IDLE);

  always_ff @(posedge phi or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_REG_WR;
      addr_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= finish;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        idx_q  <= '0;
      end else if (start) begin
        idx_q  <= idx_q + 2'd1;
      end
      if (finish && (op_q inside {OP_VRAM_RD, OP_STAT_RD})) rsp_data <= rdata;
    end
  end

  z80_io_cycle #(.WAIT_STATES(WAIT_STATES), .GAP_CYCLES(GAP_CYCLES)) u_cycle (
    .phi     (phi),
    .reset   (reset),
    .start   (start),
    .is_read (nxt.is_read),
    .mode    (nxt.mode),
    .data    (nxt.value),
    .done    (done),
    .rdata   (rdata),
    .vdp_mode(vdp_mode),
    .vdp_dout(vdp_dout),
    .vdp_wr  (vdp_wr),
    .vdp_rd  (vdp_rd),
    .vdp_din (vdp_din)
  );

endmodule
